// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: external memory bus sequencer and two-port arbiter.
//
// Serves single-word requests from the instruction-fetch port (read only)
// and the data port (read/write), one multiplexed address/data bus cycle at
// a time: IDLE -> ADDR (1 cycle) -> DATA (1+ cycles, nWait extends) ->
// TURN (1 cycle, Ack) -> IDLE. All outputs are registered.
//
// Optional feature macro: BUS_TIMEOUT_EN
//   defined   : DATA aborts after MAX_WAIT consecutive nWait-low cycles,
//               completing with Ack and BusErr=1 (read data not updated).
//   undefined : DATA waits indefinitely, BusErr is always 0.
//
// Ports:
//   Clock, nReset              system clock, async active-low reset
//   IfReq/IfAddr/IfAck/IfRData fetch port (read only)
//   DReq/DWrite/DAddr/DWData   data port request
//   DAck/DRData                data port completion / read data
//   BusErr                     high with the Ack of a timed-out access
//   BusOut/BusIn               multiplexed address/write data out, read data in
//   ALE/nME/nOE/nWE/ENB        bus strobes and pad output enable
//   nWait                      memory wait request (active low)
module mem_bus_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        IfReq,
  input  logic [15:0] IfAddr,
  output logic        IfAck,
  output logic [15:0] IfRData,
  input  logic        DReq,
  input  logic        DWrite,
  input  logic [15:0] DAddr,
  input  logic [15:0] DWData,
  output logic        DAck,
  output logic [15:0] DRData,
  output logic        BusErr,
  output logic [15:0] BusOut,
  input  logic [15:0] BusIn,
  output logic        ALE,
  output logic        nME,
  output logic        nOE,
  output logic        nWE,
  output logic        ENB,
  input  logic        nWait
);

  localparam int unsigned DW = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_TURN = 2'd3;

  // Elaboration-time guard on the timeout limit.
  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("mem_bus_ctrl: MAX_WAIT must be in 1..255");
  end

  // Latched winner of arbitration; the address lives in BusOut itself.
  typedef struct packed {
    logic          is_data;
    logic          wr;
    logic [DW-1:0] wdata;
  } xfer_t;

  logic [1:0] state, state_nxt;
  xfer_t      xfer, xfer_nxt;
  logic       last_data, last_data_nxt;   // 1 = data port was served last

  logic          ale_nxt, nme_nxt, noe_nxt, nwe_nxt, enb_nxt;
  logic          if_ack_nxt, d_ack_nxt, bus_err_nxt;
  logic [DW-1:0] bus_out_nxt, if_rdata_nxt, d_rdata_nxt;

  logic pick_data;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
`endif

  // Round-robin pick: data wins only if fetch is idle or fetch was served last.
  assign pick_data = DReq && (!IfReq || !last_data);

  // State and output registers.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state     <= S_IDLE;
      xfer      <= '0;
      last_data <= 1'b1;
      ALE       <= 1'b0;
      nME       <= 1'b1;
      nOE       <= 1'b1;
      nWE       <= 1'b1;
      ENB       <= 1'b0;
      BusOut    <= '0;
      IfAck     <= 1'b0;
      DAck      <= 1'b0;
      BusErr    <= 1'b0;
      IfRData   <= '0;
      DRData    <= '0;
`ifdef BUS_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      state     <= state_nxt;
      xfer      <= xfer_nxt;
      last_data <= last_data_nxt;
      ALE       <= ale_nxt;
      nME       <= nme_nxt;
      nOE       <= noe_nxt;
      nWE       <= nwe_nxt;
      ENB       <= enb_nxt;
      BusOut    <= bus_out_nxt;
      IfAck     <= if_ack_nxt;
      DAck      <= d_ack_nxt;
      BusErr    <= bus_err_nxt;
      IfRData   <= if_rdata_nxt;
      DRData    <= d_rdata_nxt;
`ifdef BUS_TIMEOUT_EN
      wait_cnt  <= wait_cnt_nxt;
`endif
    end
  end

  // Next state and next registered outputs (outputs reflect the state entered).
  always_comb begin
    state_nxt     = state;
    xfer_nxt      = xfer;
    last_data_nxt = last_data;
    ale_nxt       = 1'b0;
    nme_nxt       = 1'b1;
    noe_nxt       = 1'b1;
    nwe_nxt       = 1'b1;
    enb_nxt       = 1'b0;
    bus_out_nxt   = BusOut;
    if_ack_nxt    = 1'b0;
    d_ack_nxt     = 1'b0;
    bus_err_nxt   = 1'b0;
    if_rdata_nxt  = IfRData;
    d_rdata_nxt   = DRData;
`ifdef BUS_TIMEOUT_EN
    wait_cnt_nxt  = wait_cnt;
`endif

    case (state)
      S_IDLE: begin
        if (IfReq || DReq) begin
          xfer_nxt.is_data = pick_data;
          xfer_nxt.wr      = pick_data && DWrite;
          xfer_nxt.wdata   = DWData;
          state_nxt        = S_ADDR;
          ale_nxt          = 1'b1;
          enb_nxt          = 1'b1;
          bus_out_nxt      = pick_data ? DAddr : IfAddr;
        end
      end

      S_ADDR: begin
        state_nxt = S_DATA;
        nme_nxt   = 1'b0;
        if (xfer.wr) begin
          nwe_nxt     = 1'b0;
          enb_nxt     = 1'b1;
          bus_out_nxt = xfer.wdata;
        end else begin
          noe_nxt = 1'b0;
        end
`ifdef BUS_TIMEOUT_EN
        wait_cnt_nxt = '0;
`endif
      end

      S_DATA: begin
        if (nWait) begin
          // Normal completion: capture read data for the winner only.
          state_nxt     = S_TURN;
          last_data_nxt = xfer.is_data;
          if (xfer.is_data) begin
            d_ack_nxt = 1'b1;
            if (!xfer.wr) d_rdata_nxt = BusIn;
          end else begin
            if_ack_nxt   = 1'b1;
            if_rdata_nxt = BusIn;
          end
`ifdef BUS_TIMEOUT_EN
        end else if (wait_cnt == CW'(MAX_WAIT)) begin
          // Timeout abort: Ack with BusErr, read data left untouched.
          state_nxt     = S_TURN;
          last_data_nxt = xfer.is_data;
          bus_err_nxt   = 1'b1;
          if (xfer.is_data) d_ack_nxt  = 1'b1;
          else              if_ack_nxt = 1'b1;
`endif
        end else begin
          // Wait extension: hold nME and the active strobe low.
          nme_nxt = 1'b0;
          if (xfer.wr) begin
            nwe_nxt     = 1'b0;
            enb_nxt     = 1'b1;
            bus_out_nxt = xfer.wdata;
          end else begin
            noe_nxt = 1'b0;
          end
`ifdef BUS_TIMEOUT_EN
          wait_cnt_nxt = wait_cnt + CW'(1);
`endif
        end
      end

      S_TURN: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed test of mem_bus_ctrl with hand-computed expectations.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_bus_ctrl;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned TB_MAX_WAIT = 3;
`else
  localparam int unsigned TB_MAX_WAIT = 15;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ack;
  logic [15:0] if_rdata;
  logic        d_req;
  logic        d_write;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        bus_err;
  logic [15:0] bus_out;
  logic [15:0] bus_in;
  logic        ale, n_me, n_oe, n_we, enb;
  logic        n_wait;
  logic [7:0]  ctl;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  mem_bus_ctrl #(.MAX_WAIT(TB_MAX_WAIT)) dut (
    .Clock   (clk),
    .nReset  (rst_n),
    .IfReq   (if_req),
    .IfAddr  (if_addr),
    .IfAck   (if_ack),
    .IfRData (if_rdata),
    .DReq    (d_req),
    .DWrite  (d_write),
    .DAddr   (d_addr),
    .DWData  (d_wdata),
    .DAck    (d_ack),
    .DRData  (d_rdata),
    .BusErr  (bus_err),
    .BusOut  (bus_out),
    .BusIn   (bus_in),
    .ALE     (ale),
    .nME     (n_me),
    .nOE     (n_oe),
    .nWE     (n_we),
    .ENB     (enb),
    .nWait   (n_wait)
  );

  // Control snapshot: {ALE,nME,nOE,nWE,ENB,IfAck,DAck,BusErr}.
  assign ctl = {ale, n_me, n_oe, n_we, enb, if_ack, d_ack, bus_err};

  localparam logic [7:0] C_IDLE   = 8'h70;
  localparam logic [7:0] C_ADDR   = 8'hF8;
  localparam logic [7:0] C_RD     = 8'h10;
  localparam logic [7:0] C_WR     = 8'h28;
  localparam logic [7:0] C_IFACK  = 8'h74;
  localparam logic [7:0] C_DACK   = 8'h72;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    if_req  = 1'b0;
    d_req   = 1'b0;
    d_write = 1'b0;
    n_wait  = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic seen;
    if_addr = '0; d_addr = '0; d_wdata = '0; bus_in = '0;

    // Reset state.
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_write = 1'b0; n_wait = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ctl", 32'(ctl), 32'(C_IDLE));
    check("rst_busout", 32'(bus_out), 32'h0);
    check("rst_ifrdata", 32'(if_rdata), 32'h0);
    check("rst_drdata", 32'(d_rdata), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fetch read, zero wait.
    if_req = 1'b1; if_addr = 16'h0040; bus_in = 16'hA5A5;
    @(negedge clk);
    check("f_addr_ctl", 32'(ctl), 32'(C_ADDR));
    check("f_addr_bus", 32'(bus_out), 32'h0040);
    @(negedge clk);
    check("f_data_ctl", 32'(ctl), 32'(C_RD));
    @(negedge clk);
    check("f_turn_ctl", 32'(ctl), 32'(C_IFACK));
    check("f_rdata", 32'(if_rdata), 32'hA5A5);
    if_req = 1'b0;
    @(negedge clk);
    check("f_idle_ctl", 32'(ctl), 32'(C_IDLE));

    // Data write with two wait cycles.
    d_req = 1'b1; d_write = 1'b1; d_addr = 16'h1234; d_wdata = 16'hBEEF;
    @(negedge clk);
    check("w_addr_ctl", 32'(ctl), 32'(C_ADDR));
    check("w_addr_bus", 32'(bus_out), 32'h1234);
    n_wait = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("w_data_ctl%0d", c), 32'(ctl), 32'(C_WR));
      check($sformatf("w_data_bus%0d", c), 32'(bus_out), 32'hBEEF);
      if (c == 4) n_wait = 1'b1;
    end
    @(negedge clk);
    check("w_turn_ctl", 32'(ctl), 32'(C_DACK));
    check("w_drdata", 32'(d_rdata), 32'h0);
    check("w_ifrdata", 32'(if_rdata), 32'hA5A5);
    d_req = 1'b0; d_write = 1'b0;
    @(negedge clk);

    // Contention from reset: fetch, data, fetch, data, 4 cycles apart.
    do_reset();
    if_req = 1'b1; if_addr = 16'h0100;
    d_req = 1'b1; d_write = 1'b0; d_addr = 16'h2000;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      check($sformatf("ct_ifack%0d", c), 32'(if_ack), 32'((c == 3) || (c == 11)));
      check($sformatf("ct_dack%0d", c), 32'(d_ack), 32'((c == 7) || (c == 15)));
      if (c == 1 || c == 9)  check($sformatf("ct_abus%0d", c), 32'(bus_out), 32'h0100);
      if (c == 5 || c == 13) check($sformatf("ct_abus%0d", c), 32'(bus_out), 32'h2000);
      if (c == 3)  begin check("ct_ifr1", 32'(if_rdata), 32'h1002); check("ct_dr0", 32'(d_rdata), 32'h0); end
      if (c == 7)  check("ct_dr1", 32'(d_rdata), 32'h1006);
      if (c == 11) begin check("ct_ifr2", 32'(if_rdata), 32'h100A); check("ct_dr_keep", 32'(d_rdata), 32'h1006); end
      if (c == 15) begin check("ct_dr2", 32'(d_rdata), 32'h100E); check("ct_ifr_keep", 32'(if_rdata), 32'h100A); end
      bus_in = 16'h1000 + 16'(c);
      if (c == 15) begin if_req = 1'b0; d_req = 1'b0; end
    end

    // Reset mid-access during DATA: immediate reset values, no Ack.
    d_req = 1'b1; d_write = 1'b0; d_addr = 16'h4000; n_wait = 1'b0;
    repeat (2) @(negedge clk);
    check("rm_data_ctl", 32'(ctl), 32'(C_RD));
    #2 rst_n = 1'b0;
    #1;
    check("rm_ctl", 32'(ctl), 32'(C_IDLE));
    check("rm_busout", 32'(bus_out), 32'h0);
    check("rm_drdata", 32'(d_rdata), 32'h0);
    check("rm_ifrdata", 32'(if_rdata), 32'h0);
    d_req = 1'b0; n_wait = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rm_noack%0d", c), 32'(ctl), 32'(C_IDLE));
    end
    d_req = 1'b1; d_addr = 16'h3000; bus_in = 16'h5A5A;
    repeat (3) @(negedge clk);
    check("rm_next_ctl", 32'(ctl), 32'(C_DACK));
    check("rm_next_dr", 32'(d_rdata), 32'h5A5A);
    d_req = 1'b0;
    @(negedge clk);

`ifdef BUS_TIMEOUT_EN
    // Timeout: nWait held low, abort after MAX_WAIT wait cycles.
    d_req = 1'b1; d_write = 1'b0; d_addr = 16'h3002; n_wait = 1'b0; bus_in = 16'hFFFF;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c < 6) check($sformatf("to_wait%0d", c), 32'({d_ack, bus_err}), 32'h0);
    end
    check("to_ack_ctl", 32'(ctl), 32'h73);
    check("to_drdata", 32'(d_rdata), 32'h5A5A);
    d_req = 1'b0; n_wait = 1'b1;
    @(negedge clk);
    check("to_after", 32'(ctl), 32'(C_IDLE));
`else
    // Long wait without timeout: 100 nWait-low cycles, then completion.
    seen = 1'b0;
    if_req = 1'b1; if_addr = 16'h0200; n_wait = 1'b0;
    for (int c = 1; c <= 102; c++) begin
      @(negedge clk);
      seen = seen | if_ack | bus_err;
      if (c == 102) begin n_wait = 1'b1; bus_in = 16'hC3C3; end
    end
    check("lw_early", 32'(seen), 32'h0);
    @(negedge clk);
    check("lw_ack_ctl", 32'(ctl), 32'(C_IFACK));
    check("lw_ifrdata", 32'(if_rdata), 32'hC3C3);
    if_req = 1'b0;
    @(negedge clk);
    check("lw_after", 32'(ctl), 32'(C_IDLE));
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
